// File: rtl/mux8_drain_seq_pkg.sv
// Shared types and widths for the MUX8 drain sequencer.
// The FSM walks IDLE -> FETCH -> HOLD, and HOLD repeats once per word.
package mux8_drain_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} drain_state_t;

endpackage

// File: rtl/mux8_drain_seq_if.sv
// Bundles the sequencer's control, MUX8 and readout-stream signals.
// The master modport is the sequencer. The slave modport is the surrounding logic.
interface mux8_drain_seq_if;
    import mux8_drain_pkg::*;

    logic              start;
    logic [SEL_W-1:0]  last_sel;
    logic [SEL_W-1:0]  mux_select;
    logic              mux_enable;
    logic [DATA_W-1:0] mux_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, last_sel, mux_data, out_ready,
        output mux_select, mux_enable, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        output start, last_sel, mux_data, out_ready,
        input  mux_select, mux_enable, out_data, out_valid, out_last, busy, done
    );

endinterface

// File: rtl/mux8_drain_seq.sv
// Walks the MUX8 select from 0 to a latched last index.
// It registers each selected word onto a valid/ready stream at up to one word per cycle.
module mux8_drain_seq
    import mux8_drain_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    mux8_drain_seq_if.master bus
);

    drain_state_t      state;
    drain_state_t      next_state;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  last;
    logic [SEL_W-1:0]  hidx;
    logic              capture;
    logic              finish;
    logic              busy_c;
    logic              enable_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = FETCH;
            FETCH:   next_state = HOLD;
            HOLD:    if (bus.out_ready && (hidx == last)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A capture in HOLD refills the output register in the same edge as the handshake.
    always_comb begin
        capture  = 1'b0;
        finish   = 1'b0;
        busy_c   = 1'b0;
        enable_c = 1'b0;
        case (state)
            FETCH: begin
                busy_c  = 1'b1;
                capture = 1'b1;
            end
            HOLD: begin
                busy_c  = 1'b1;
                capture = bus.out_ready && (hidx != last);
                finish  = bus.out_ready && (hidx == last);
            end
            default: begin
                busy_c = 1'b0;
            end
        endcase
        enable_c = capture;
    end

    assign bus.mux_select = ptr;
    assign bus.mux_enable = enable_c;
    assign bus.busy       = busy_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr           <= '0;
            last          <= '0;
            hidx          <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if ((state == IDLE) && bus.start) begin
                last <= bus.last_sel;
                ptr  <= '0;
            end
            if (capture) begin
                bus.out_data  <= bus.mux_data;
                hidx          <= ptr;
                ptr           <= ptr + 1'b1;
                bus.out_valid <= 1'b1;
                bus.out_last  <= (ptr == last);
            end
            if (finish) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
                bus.done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux8_drain_seq.sv
// Directed bench for mux8_drain_seq, with a behavioural MUX8 model feeding the sequencer.
module tb_mux8_drain_seq;
    import mux8_drain_pkg::*;

    logic clk;
    logic reset_n;
    logic [DATA_W-1:0] src [8];
    int checks;
    int fails;

    mux8_drain_seq_if bus ();

    mux8_drain_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always_comb bus.mux_data = bus.mux_enable ? src[bus.mux_select] : '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus.start = 1'b1;
        bus.last_sel = 3'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.out_last, bus.busy, bus.done, bus.mux_enable} !== 5'b0) begin
                fails++;
                $display("[TB] FAIL reset_ctrl got %b want 00000",
                         {bus.out_valid, bus.out_last, bus.busy, bus.done, bus.mux_enable});
            end
            checks++;
            if (bus.out_data !== 32'h0 || bus.mux_select !== 3'd0) begin
                fails++;
                $display("[TB] FAIL reset_data got %h/%0d want 0/0", bus.out_data, bus.mux_select);
            end
        end
        reset_n = 1'b1;
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mux_enable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_release busy=%b done=%b en=%b want 0 0 0",
                     bus.busy, bus.done, bus.mux_enable);
        end
    endtask

    task automatic test_full_drain;
        int busy_cycles;
        busy_cycles = 0;
        bus.last_sel = 3'd7;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (bus.busy === 1'b1) busy_cycles++;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.mux_enable !== 1'b1 || bus.mux_select !== 3'd0) begin
            fails++;
            $display("[TB] FAIL full_fetch valid=%b en=%b sel=%0d want 0 1 0",
                     bus.out_valid, bus.mux_enable, bus.mux_select);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.busy === 1'b1) busy_cycles++;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1000_0000 + i) begin
                fails++;
                $display("[TB] FAIL full_word%0d got v=%b %h want v=1 %h",
                         i, bus.out_valid, bus.out_data, 32'h1000_0000 + i);
            end
            checks++;
            if (bus.out_last !== (i == 7) || bus.done !== 1'b0) begin
                fails++;
                $display("[TB] FAIL full_last%0d got last=%b done=%b want last=%b done=0",
                         i, bus.out_last, bus.done, (i == 7));
            end
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL full_done done=%b busy=%b valid=%b want 1 0 0",
                     bus.done, bus.busy, bus.out_valid);
        end
        checks++;
        if (busy_cycles !== 9) begin
            fails++;
            $display("[TB] FAIL full_busy_len got %0d want 9", busy_cycles);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL full_done_pulse got %b want 0", bus.done);
        end
    endtask

    task automatic test_backpressure;
        logic pat [4];
        int   exp_idx;
        bit   exp_done;
        bit   finished;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        exp_idx = 0;
        exp_done = 1'b0;
        finished = 1'b0;
        bus.last_sel = 3'd3;
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 40 && !finished; k++) begin
            tick();
            if (exp_done) begin
                finished = 1'b1;
                checks++;
                if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL bp_done done=%b valid=%b want 1 0", bus.done, bus.out_valid);
                end
            end else begin
                bus.out_ready = pat[k % 4];
                #1;
                checks++;
                if (bus.done !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL bp_early_done got %b want 0", bus.done);
                end
                if (bus.out_valid === 1'b1) begin
                    checks++;
                    if (bus.out_data !== src[exp_idx] || bus.out_last !== (exp_idx == 3)) begin
                        fails++;
                        $display("[TB] FAIL bp_word got %h last=%b want %h last=%b",
                                 bus.out_data, bus.out_last, src[exp_idx], (exp_idx == 3));
                    end
                    checks++;
                    if (bus.mux_enable !== (bus.out_ready && exp_idx != 3)) begin
                        fails++;
                        $display("[TB] FAIL bp_enable got %b want %b",
                                 bus.mux_enable, (bus.out_ready && exp_idx != 3));
                    end
                    if (bus.out_ready) begin
                        if (exp_idx == 3) exp_done = 1'b1;
                        exp_idx++;
                    end
                end
            end
        end
        checks++;
        if (!finished || exp_idx !== 4) begin
            fails++;
            $display("[TB] FAIL bp_timeout finished=%b words=%0d want 1 4", finished, exp_idx);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_single_word;
        bus.last_sel = 3'd0;
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== src[0] || bus.out_last !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_word got v=%b %h last=%b want v=1 %h last=1",
                     bus.out_valid, bus.out_data, bus.out_last, src[0]);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.mux_enable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_enable got %b want 0", bus.mux_enable);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_done done=%b busy=%b want 1 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_boundaries;
        bus.last_sel = 3'd2;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        bus.last_sel = 3'd5;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.out_data !== src[1] || bus.out_last !== 1'b0) begin
            fails++;
            $display("[TB] FAIL busy_start_w1 got %h last=%b want %h last=0",
                     bus.out_data, bus.out_last, src[1]);
        end
        tick();
        checks++;
        if (bus.out_data !== src[2] || bus.out_last !== 1'b1) begin
            fails++;
            $display("[TB] FAIL lastsel_ignored got %h last=%b want %h last=1",
                     bus.out_data, bus.out_last, src[2]);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bound_done got %b want 1", bus.done);
        end
        bus.start = 1'b1;
        bus.last_sel = 3'd1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.mux_select !== 3'd0) begin
            fails++;
            $display("[TB] FAIL done_start busy=%b valid=%b sel=%0d want 1 0 0",
                     bus.busy, bus.out_valid, bus.mux_select);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== src[0] || bus.out_last !== 1'b0) begin
            fails++;
            $display("[TB] FAIL done_start_w0 got v=%b %h last=%b want v=1 %h last=0",
                     bus.out_valid, bus.out_data, bus.out_last, src[0]);
        end
        tick();
        checks++;
        if (bus.out_data !== src[1] || bus.out_last !== 1'b1) begin
            fails++;
            $display("[TB] FAIL done_start_w1 got %h last=%b want %h last=1",
                     bus.out_data, bus.out_last, src[1]);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL done_start_done got %b want 1", bus.done);
        end
    endtask

    task automatic test_reset_mid_drain;
        bus.last_sel = 3'd7;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.out_data !== src[2]) begin
            fails++;
            $display("[TB] FAIL mid_word2 got %h want %h", bus.out_data, src[2]);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_data !== 32'h0) begin
            fails++;
            $display("[TB] FAIL mid_reset v=%b busy=%b done=%b data=%h want 0 0 0 0",
                     bus.out_valid, bus.busy, bus.done, bus.out_data);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_no_done done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
        bus.last_sel = 3'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== src[0]) begin
            fails++;
            $display("[TB] FAIL mid_restart_w0 got v=%b %h want v=1 %h",
                     bus.out_valid, bus.out_data, src[0]);
        end
        tick();
        checks++;
        if (bus.out_data !== src[1] || bus.out_last !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_restart_w1 got %h last=%b want %h last=1",
                     bus.out_data, bus.out_last, src[1]);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_restart_done got %b want 1", bus.done);
        end
    endtask

    initial begin
        clk = 1'b0;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.last_sel = 3'd0;
        bus.out_ready = 1'b0;
        checks = 0;
        fails = 0;
        for (int i = 0; i < 8; i++) src[i] = 32'h1000_0000 + i;
        test_reset();
        test_full_drain();
        test_backpressure();
        test_single_word();
        test_boundaries();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
